// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch unit: state encodings,
// the default reset PC and the layout of a buffered fetch entry.
package fetch_pkg;

  // Byte address of the first instruction fetched after reset
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  // Fetch control states, kept as plain constants so older blocks can share them
  localparam logic [1:0] ST_RUN   = 2'd0;
  localparam logic [1:0] ST_HALT  = 2'd1;
  localparam logic [1:0] ST_FAULT = 2'd2;

  // Depth of the fetch buffer between fetch and decode
  localparam int unsigned BUF_DEPTH = 2;

  // One buffered fetch: the byte address together with the fetched word
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

  // A redirect target is usable only when it is word aligned
  function automatic logic is_word_aligned(input logic [31:0] addr);
    return (addr[1:0] == 2'b00);
  endfunction

endpackage

// File: rtl/fetch_buffer.sv
// Two-entry FIFO holding {pc, instr} pairs between fetch and decode.
// A flush empties the buffer and wins over any push or pop in the same cycle.
module fetch_buffer
  import fetch_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  fetch_entry_t push_data,
  output fetch_entry_t head_data,
  output logic [1:0]   count
);

  fetch_entry_t mem [BUF_DEPTH];
  logic         wr_ptr;
  logic         rd_ptr;
  logic [1:0]   count_q;
  logic         do_push;
  logic         do_pop;

  // Qualify requests so the buffer never underflows or overflows on its own
  always_comb begin
    do_pop  = pop && (count_q != 2'd0) && !flush;
    do_push = push && !flush && ((count_q != 2'd2) || do_pop);
  end

  // Pointer and occupancy bookkeeping; flush returns everything to empty
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr  <= 1'b0;
      rd_ptr  <= 1'b0;
      count_q <= 2'd0;
    end else if (flush) begin
      wr_ptr  <= 1'b0;
      rd_ptr  <= 1'b0;
      count_q <= 2'd0;
    end else begin
      if (do_push) begin
        wr_ptr <= ~wr_ptr;
      end
      if (do_pop) begin
        rd_ptr <= ~rd_ptr;
      end
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 2'd1;
        2'b01:   count_q <= count_q - 2'd1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Payload storage needs no reset; the head is only meaningful when count is non-zero
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  assign head_data = mem[rd_ptr];
  assign count     = count_q;

endmodule

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit: walks a combinational instruction ROM from RESET_PC,
// buffers fetched words for decode, follows redirects, halts past the ROM end
// and latches a sticky fault on a misaligned redirect target.
module instruction_fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = DEFAULT_RESET_PC,
  parameter int unsigned ROM_BYTES = 28
) (
  input  logic        clk_i,
  input  logic        rst_i,
  output logic [31:0] imem_addr_o,
  input  logic [31:0] imem_instr_i,
  output logic        instr_valid_o,
  input  logic        instr_ready_i,
  output logic [31:0] instr_o,
  output logic [31:0] pc_o,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic        halted_o,
  output logic        fault_o
);

  // Address of the last whole word inside the ROM
  localparam logic [31:0] LAST_PC = 32'(ROM_BYTES - 4);

  logic [1:0]   state_q;
  logic [1:0]   state_d;
  logic [31:0]  fetch_pc_q;
  logic [31:0]  fetch_pc_d;
  logic         push;
  logic         flush;
  logic         transfer;
  logic [1:0]   count;
  fetch_entry_t push_data;
  fetch_entry_t head_data;

  assign transfer    = instr_valid_o && instr_ready_i;
  assign imem_addr_o = fetch_pc_q;

  assign push_data.pc    = fetch_pc_q;
  assign push_data.instr = imem_instr_i;

  // Next-state logic: redirects take priority, then the ROM-end check, then fetching
  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    push       = 1'b0;
    flush      = 1'b0;
    case (state_q)
      ST_RUN, ST_HALT: begin
        if (redirect_i) begin
          flush = 1'b1;
          if (is_word_aligned(redirect_pc_i)) begin
            fetch_pc_d = redirect_pc_i;
            state_d    = ST_RUN;
          end else begin
            state_d = ST_FAULT;
          end
        end else if (state_q == ST_RUN) begin
          if (fetch_pc_q > LAST_PC) begin
            state_d = ST_HALT;
          end else if ((count != 2'd2) || transfer) begin
            push       = 1'b1;
            fetch_pc_d = fetch_pc_q + 32'd4;
          end
        end
      end
      default: begin
        state_d = ST_FAULT;
      end
    endcase
  end

  // Fetch PC and control state registers
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= ST_RUN;
      fetch_pc_q <= RESET_PC;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
    end
  end

  // The head is consumed on every transfer; a simultaneous flush still empties the buffer
  fetch_buffer u_buffer (
    .clk       (clk_i),
    .rst       (rst_i),
    .push      (push),
    .pop       (transfer),
    .flush     (flush),
    .push_data (push_data),
    .head_data (head_data),
    .count     (count)
  );

  // Head outputs read as zero whenever the buffer is empty
  always_comb begin
    instr_valid_o = (count != 2'd0);
    instr_o       = instr_valid_o ? head_data.instr : 32'h0;
    pc_o          = instr_valid_o ? head_data.pc    : 32'h0;
    halted_o      = (state_q == ST_HALT) && (count == 2'd0);
    fault_o       = (state_q == ST_FAULT);
  end

endmodule

// File: doc/instruction_fetch_unit.md
INSTRUCTION_FETCH_UNIT -- requirements
Module: instruction_fetch_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, first fetch byte address.
REQ-002 SHALL have parameter ROM_BYTES, default 28, instruction ROM size in bytes (multiple of 4).
REQ-003 SHALL have port clk_i  input  1  sole clock; all state on rising edge.
REQ-004 SHALL have port rst_i  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port imem_addr_o  output  32  byte address to combinational instruction ROM.
REQ-006 SHALL have port imem_instr_i  input  32  ROM word at imem_addr_o, same cycle.
REQ-007 SHALL have port instr_valid_o  output  1  head of fetch buffer valid.
REQ-008 SHALL have port instr_ready_i  input  1  decode accepts head; transfer when valid&ready.
REQ-009 SHALL have port instr_o  output  32  head instruction.
REQ-010 SHALL have port pc_o  output  32  byte address of head instruction.
REQ-011 SHALL have port redirect_i  input  1  branch/jump redirect strobe.
REQ-012 SHALL have port redirect_pc_i  input  32  redirect target byte address.
REQ-013 SHALL have port halted_o  output  1  fetch past ROM end and buffer empty.
REQ-014 SHALL have port fault_o  output  1  misaligned redirect captured; sticky.

Function
REQ-015 SHALL hold fetch_pc register and drive imem_addr_o = fetch_pc combinationally.
REQ-016 SHALL buffer {pc, instr} in a 2-entry FIFO; instr_valid_o = (count != 0), instr_o/pc_o from head, no bypass.
REQ-017 SHALL implement states RUN, HALT, FAULT.
REQ-018 In RUN, SHALL push {fetch_pc, imem_instr_i} and advance fetch_pc by 4 when no redirect and (count<2 or transfer this cycle).
REQ-019 SHALL allow simultaneous push and pop with count unchanged.
REQ-020 SHALL transition RUN->HALT, without push, when fetch_pc > ROM_BYTES-4; buffered entries still drain in HALT.
REQ-021 SHALL assert halted_o only when state is HALT and count == 0.
REQ-022 On redirect_i with redirect_pc_i[1:0]==0, SHALL flush FIFO (count=0), skip push, load fetch_pc=redirect_pc_i, enter RUN from RUN or HALT.
REQ-023 SHALL treat a transfer in the redirect cycle as completed (head consumed); the flush overrides the pop.
REQ-024 On redirect_i with redirect_pc_i[1:0]!=0, SHALL flush FIFO, enter FAULT, assert fault_o.
REQ-025 In FAULT, SHALL never push, SHALL ignore redirect_i, SHALL exit only via reset.
REQ-026 Latency: instruction fetched in cycle t SHALL appear on instr_o no earlier than cycle t+1; redirect in cycle t yields target on instr_o at cycle t+2.
REQ-027 Sustained throughput SHALL be one instruction per cycle with instr_ready_i held high.
REQ-028 fetch_pc arithmetic SHALL be 32-bit modulo 2^32.

Reset
REQ-029 While rst_i high: fetch_pc=RESET_PC, count=0, state=RUN, instr_valid_o=0, instr_o=0, pc_o=0, halted_o=0, fault_o=0.
REQ-030 Reset mid-operation SHALL discard buffered entries immediately; first push on first rising edge after deassertion.

Structure
REQ-031 State encoding constants SHALL live in shared package fetch_pkg with default RESET_PC.
REQ-032 FIFO SHALL be sub-module fetch_buffer (2 entries, 64-bit payload, push/pop/flush, count).
REQ-033 Block SHALL instantiate with existing instruction_memory, wired via imem_addr_o/imem_instr_i.

Verification
REQ-034 Reset, ready high, ROM words W0..W6 -> pc_o 0,4,...,24 in consecutive cycles, then halted_o=1 at count 0.
REQ-035 Ready low 5 cycles after reset -> count saturates at 2, fetch_pc=8, head pc_o=0 held stable.
REQ-036 Redirect to 0x10 while buffer holds pc 4,8 -> next cycle valid=0, following cycle pc_o=0x10.
REQ-037 Redirect to 0x0 while halted -> halted_o drops, pc_o=0 two cycles later.
REQ-038 Redirect to 0x6 -> fault_o=1, valid stays 0; later redirect to 0x0 ignored; reset clears fault_o.
REQ-039 Assert rst_i mid-stream with count=2 -> instr_valid_o=0 immediately, pc_o=0 after release.
